reg_xfer_arbiter: RTL and testbench
===================================

# reg_xfer_arbiter

Shared-register-bank transfer controller. Two requesters issue load/move/swap/shift operations over a valid/ready handshake. A round-robin arbiter grants at most one operation per cycle, and a one-deep execute stage applies it to a 4-entry register bank with simultaneous-update semantics: every destination updates from pre-edge values, as with non-blocking assignment. The block sits between the test and sequencing logic and the small register datapath it owns, and makes ordered multi-register updates deterministic.

## Interface
- WIDTH, 8, data width of each bank register
- clk  in  1  rising-edge clock, sole clock domain
- rst_n  in  1  asynchronous active-low reset
- reqN_valid (N=0,1)  in  1  requester N presents an operation
- reqN_ready  out  1  requester N's operation is accepted this cycle (combinational)
- reqN_op  in  2  00 LOAD, 01 MOVE, 10 SWAP, 11 SHIFT
- reqN_src  in  2  source register index
- reqN_dst  in  2  destination register index
- reqN_data  in  WIDTH  immediate operand (LOAD, SHIFT)
- hold  in  1  1 = grant nothing this cycle
- rd_idx  in  2  debug read index
- rd_data  out  WIDTH  bank[rd_idx], combinational from bank registers
- done_valid  out  1  one-cycle pulse: an operation was applied at the preceding edge
- done_id  out  1  requester index of the applied operation

## Operation
- Handshake: an operation transfers on an edge where reqN_valid && reqN_ready. Requesters hold valid/op/src/dst/data stable until accepted. reqN_ready never depends on the same requester's op fields.
- Arbitration: ready is 0 for both requesters when hold=1. Otherwise:
  - one requester valid: it is granted.
  - both valid: the requester with priority is granted.
- Priority pointer: it points away from the last granted requester and updates only on a grant.
- Execute stage: an accepted op is captured into the exec register (exec_valid, op, src, dst, data, id). At the next edge it is applied to the bank. All right-hand sides read the bank value before that edge.
- LOAD: bank[dst] <= data.
- MOVE: bank[dst] <= bank[src]. If src==dst, the bank is unchanged.
- SWAP: bank[src] <= bank[dst] and bank[dst] <= bank[src], simultaneously. If src==dst, the bank is unchanged.
- SHIFT: bank[dst] <= bank[src] and bank[src] <= data, simultaneously. If src==dst, bank[dst] <= data (data wins).
- Throughput: one op per cycle. Accept and execute overlap, so the exec register is refilled on the same edge it is applied.
- Ordering: op k+1 executes one edge after op k, so op k+1 reads op k's results. There is no hazard stall.
- done_valid/done_id are registered. They are 1/id during the cycle following the applying edge, and done_valid is 0 otherwise.

## Timing
- Reset values (asserted asynchronously): bank[0..3]=0, exec_valid=0, done_valid=0, done_id=0, priority pointer=requester 0. reqN_ready follows the arbitration logic from reset values.
- Latency: accept at edge E; bank updated at edge E+1; done_valid high in the cycle after E+1; rd_data shows the new value in the cycle after E+1.
- Reset mid-operation: an op sitting in the exec register is discarded. It writes no bank entry and produces no done pulse.
- Deassertion of rst_n: ops are accepted from the first rising edge after release.
- hold=1 while the exec register is full: the held op still executes. Only new grants stop.
- Simultaneous valid on both requesters every cycle: grants alternate 0,1,0,1… starting from the pointer.
- An invalid requester never consumes priority.

## Test plan
- Reset, then read all 4 via rd_idx -> rd_data=0. Assert rst_n low mid-op (exec_valid=1) -> no done pulse, bank stays 0.
- req0 LOAD r0=0x11, LOAD r1=0x22 back-to-back, then SWAP src=0 dst=1 -> r0=0x22, r1=0x11. done_valid pulses once per op, 2 edges after its accept.
- From r0=0x22, r1=0x11: MOVE src=0 dst=2, then MOVE src=2 dst=3 on consecutive cycles -> r3=0x22 (second op sees the first's result). Then SHIFT src=1 dst=0 data=0x55 -> r0=0x11, r1=0x55.
- Both requesters valid continuously, 6 LOADs each, pointer at 0 -> grants 0,1,0,1,… and done_id alternates. hold=1 for 2 cycles mid-stream -> no grants during those cycles, alternation resumes where it stopped.
- Edge cases: SWAP src=dst=2 with r2=0x3C -> unchanged. SHIFT src=dst=1 data=0xA5 -> r1=0xA5. MOVE src=dst -> unchanged. Only req1 valid after a req1 grant -> req1 granted again.

Source files
------------

// File: rtl/reg_xfer_arbiter.sv
// Two-requester round-robin transfer controller over a 4-entry register bank.
// Ops are captured into a one-deep exec stage and applied with simultaneous-update semantics.
module reg_xfer_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [1:0]       req0_src,
    input  logic [1:0]       req0_dst,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [1:0]       req1_src,
    input  logic [1:0]       req1_dst,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             hold,
    input  logic [1:0]       rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic             done_valid,
    output logic             done_id
);

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_MOVE  = 2'b01,
        OP_SWAP  = 2'b10,
        OP_SHIFT = 2'b11
    } op_e;

    logic [WIDTH-1:0] bank     [4];
    logic [WIDTH-1:0] bank_nxt [4];

    // ptr=0: requester 0 wins a tie; ptr=1: requester 1 wins
    logic             ptr;
    logic             grant0;
    logic             grant1;

    logic             exec_valid;
    logic             exec_id;
    op_e              exec_op;
    logic [1:0]       exec_src;
    logic [1:0]       exec_dst;
    logic [WIDTH-1:0] exec_data;

    assign grant0 = !hold && req0_valid && (!req1_valid || !ptr);
    assign grant1 = !hold && req1_valid && (!req0_valid ||  ptr);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign rd_data = bank[rd_idx];

    // Reads use the current bank only; the later write wins, so SHIFT with src==dst stores data
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bank_nxt[i] = bank[i];
        end
        case (exec_op)
            OP_LOAD: begin
                bank_nxt[exec_dst] = exec_data;
            end
            OP_MOVE: begin
                bank_nxt[exec_dst] = bank[exec_src];
            end
            OP_SWAP: begin
                bank_nxt[exec_src] = bank[exec_dst];
                bank_nxt[exec_dst] = bank[exec_src];
            end
            OP_SHIFT: begin
                bank_nxt[exec_dst] = bank[exec_src];
                bank_nxt[exec_src] = exec_data;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                bank[i] <= '0;
            end
            ptr        <= 1'b0;
            exec_valid <= 1'b0;
            exec_id    <= 1'b0;
            exec_op    <= OP_LOAD;
            exec_src   <= '0;
            exec_dst   <= '0;
            exec_data  <= '0;
            done_valid <= 1'b0;
            done_id    <= 1'b0;
        end else begin
            if (exec_valid) begin
                for (int i = 0; i < 4; i++) begin
                    bank[i] <= bank_nxt[i];
                end
            end

            exec_valid <= grant0 || grant1;
            if (grant0) begin
                exec_id   <= 1'b0;
                exec_op   <= op_e'(req0_op);
                exec_src  <= req0_src;
                exec_dst  <= req0_dst;
                exec_data <= req0_data;
            end else if (grant1) begin
                exec_id   <= 1'b1;
                exec_op   <= op_e'(req1_op);
                exec_src  <= req1_src;
                exec_dst  <= req1_dst;
                exec_data <= req1_data;
            end

            if (grant0 || grant1) begin
                ptr <= grant0;
            end

            done_valid <= exec_valid;
            if (exec_valid) begin
                done_id <= exec_id;
            end
        end
    end

endmodule

// File: tb/tb_reg_xfer_arbiter.sv
// Scoreboard bench for reg_xfer_arbiter: stimulus pushes expected done pulses,
// a negedge monitor pops and checks them; bank contents checked through rd_data.
module tb_reg_xfer_arbiter;

    localparam logic [1:0] LOAD  = 2'b00;
    localparam logic [1:0] MOVE  = 2'b01;
    localparam logic [1:0] SWAP  = 2'b10;
    localparam logic [1:0] SHIFT = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [1:0] req0_op = '0;
    logic [1:0] req0_src = '0;
    logic [1:0] req0_dst = '0;
    logic [7:0] req0_data = '0;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic [1:0] req1_op = '0;
    logic [1:0] req1_src = '0;
    logic [1:0] req1_dst = '0;
    logic [7:0] req1_data = '0;
    logic       hold = 1'b0;
    logic [1:0] rd_idx = '0;
    logic [7:0] rd_data;
    logic       done_valid;
    logic       done_id;

    typedef struct {
        bit id;
        int due;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    reg_xfer_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_src(req0_src),
        .req0_dst(req0_dst), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_src(req1_src),
        .req1_dst(req1_dst), .req1_data(req1_data),
        .hold(hold), .rd_idx(rd_idx), .rd_data(rd_data),
        .done_valid(done_valid), .done_id(done_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && done_valid) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done id=%0d cyc=%0d required no pulse", done_id, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (done_id !== e.id || cyc != e.due) begin
                    fails++;
                    $display("FAIL done_pulse got id=%0d cyc=%0d required id=%0d cyc=%0d",
                             done_id, cyc, e.id, e.due);
                end
            end
        end
    end

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%02h required=%02h", name, got, exp);
        end
    endtask

    task automatic check_reg(input logic [1:0] idx, input logic [7:0] exp);
        rd_idx = idx;
        #1;
        check8($sformatf("reg%0d", idx), rd_data, exp);
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge
    task automatic issue(input bit n, input logic [1:0] op, input logic [1:0] src,
                         input logic [1:0] dst, input logic [7:0] data, input bit expect_done);
        bit ok = 1'b0;
        int tries = 0;
        if (n == 1'b0) begin
            req1_valid = 1'b0;
            req0_valid = 1'b1; req0_op = op; req0_src = src; req0_dst = dst; req0_data = data;
        end else begin
            req0_valid = 1'b0;
            req1_valid = 1'b1; req1_op = op; req1_src = src; req1_dst = dst; req1_data = data;
        end
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            tries++;
            if ((n ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1'b1;
                if (expect_done) sb.push_back('{id: n, due: cyc + 2});
            end
            @(negedge clk);
        end
        tests++;
        if (!ok || tries != 1) begin
            fails++;
            $display("FAIL accept_req%0d op=%0d got tries=%0d accepted=%0d required tries=1 accepted=1",
                     n, op, tries, ok);
        end
    endtask

    initial begin
        int c0 = 0;
        int c1 = 0;
        int holds = 0;
        bit mp = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (done_valid !== 1'b0 || done_id !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs got dv=%0b id=%0b r0=%0b r1=%0b required 0 0 0 0",
                     done_valid, done_id, req0_ready, req1_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) check_reg(2'(i), 8'h00);

        // Reset while an op sits in the exec register
        @(negedge clk);
        issue(0, LOAD, 2'd0, 2'd0, 8'hFF, 1'b0);
        idle();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (done_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_discard got done_valid=%0b required 0", done_valid);
        end
        check_reg(2'd0, 8'h00);

        @(negedge clk);
        issue(0, LOAD, 2'd0, 2'd0, 8'h11, 1'b1);
        issue(0, LOAD, 2'd0, 2'd1, 8'h22, 1'b1);
        issue(0, SWAP, 2'd0, 2'd1, 8'h00, 1'b1);
        idle();
        repeat (2) @(negedge clk);
        check_reg(2'd0, 8'h22);
        check_reg(2'd1, 8'h11);

        @(negedge clk);
        issue(0, MOVE, 2'd0, 2'd2, 8'h00, 1'b1);
        issue(0, MOVE, 2'd2, 2'd3, 8'h00, 1'b1);
        issue(0, SHIFT, 2'd1, 2'd0, 8'h55, 1'b1);
        idle();
        repeat (2) @(negedge clk);
        check_reg(2'd3, 8'h22);
        check_reg(2'd2, 8'h22);
        check_reg(2'd0, 8'h11);
        check_reg(2'd1, 8'h55);

        // MOVE src==dst by req1 also leaves the pointer at requester 0
        @(negedge clk);
        issue(1, MOVE, 2'd1, 2'd1, 8'h00, 1'b1);
        idle();
        repeat (2) @(negedge clk);
        check_reg(2'd1, 8'h55);

        @(negedge clk);
        for (int it = 0; it < 40 && (c0 < 6 || c1 < 6); it++) begin
            bit v0, v1, h, e0, e1;
            v0 = (c0 < 6);
            v1 = (c1 < 6);
            h = (c0 + c1 == 5) && (holds < 2);
            if (h) holds++;
            hold = h;
            req0_valid = v0; req0_op = LOAD; req0_src = 2'd0; req0_dst = 2'd2; req0_data = 8'(8'h80 + c0);
            req1_valid = v1; req1_op = LOAD; req1_src = 2'd0; req1_dst = 2'd3; req1_data = 8'(8'h90 + c1);
            #1;
            e0 = !h && v0 && (!v1 || !mp);
            e1 = !h && v1 && (!v0 || mp);
            tests++;
            if (req0_ready !== e0 || req1_ready !== e1) begin
                fails++;
                $display("FAIL alternate_it%0d got ready=%0b%0b required %0b%0b",
                         it, req0_ready, req1_ready, e0, e1);
            end
            if (e0 || e1) begin
                sb.push_back('{id: e1, due: cyc + 2});
                mp = e0;
            end
            if (e0) c0++;
            if (e1) c1++;
            @(negedge clk);
        end
        idle();
        hold = 1'b0;
        repeat (2) @(negedge clk);
        check_reg(2'd2, 8'h85);
        check_reg(2'd3, 8'h95);
        check_reg(2'd1, 8'h55);

        @(negedge clk);
        issue(0, LOAD, 2'd0, 2'd2, 8'h3C, 1'b1);
        issue(0, SWAP, 2'd2, 2'd2, 8'h00, 1'b1);
        issue(0, SHIFT, 2'd1, 2'd1, 8'hA5, 1'b1);
        issue(1, LOAD, 2'd0, 2'd0, 8'h77, 1'b1);
        issue(1, LOAD, 2'd0, 2'd3, 8'h66, 1'b1);
        idle();
        repeat (2) @(negedge clk);
        check_reg(2'd2, 8'h3C);
        check_reg(2'd1, 8'hA5);
        check_reg(2'd0, 8'h77);
        check_reg(2'd3, 8'h66);

        repeat (4) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
